// File: rtl/pci_rr_arbiter.sv
// Central PCI bus arbiter: round-robin grant of active-low REQ lines, bus parking,
// hidden arbitration while the bus is busy, and masking of masters that sit on an idle grant.
module pci_rr_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned PARK    = 0,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         FRAME,
   input  logic         IRDY,
   input  logic [N-1:0] REQ,
   output logic [N-1:0] GNT,
   output logic [2:0]   OWNER,
   output logic [N-1:0] MASKED,
   output logic         BUS_IDLE
);
   localparam int unsigned IW = 3;
   localparam int unsigned SW = IW + 1;
   localparam int unsigned CW = 8;
   localparam logic [IW-1:0] PARK_IDX  = IW'(PARK);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {PARKED, GRANTED, GAP} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] ptr, ptr_nxt, owner_nxt;
   logic [IW-1:0] winner, cand;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [N-1:0]  masked_nxt, gnt_nxt, elig;
   logic          any_elig, idle, inc, expire, txn_start;

   // (a + b) mod N for indices already below N
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
      logic [SW-1:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= SW'(N)) s = s - SW'(N);
      return s[IW-1:0];
   endfunction

   function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
      logic [N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[i] = (IW'(i) == idx);
      return v;
   endfunction

   assign idle      = FRAME & IRDY;
   assign elig      = ~REQ & ~MASKED;
   assign inc       = idle & (|(~REQ & onehot(OWNER)));
   assign expire    = (state == GRANTED) & inc & (cnt == CNT_LIMIT);
   assign txn_start = (state != GAP) & ~FRAME & BUS_IDLE;

   // Rotating-priority scan starting at ptr
   always_comb begin
      winner   = ptr;
      any_elig = 1'b0;
      cand     = '0;
      for (int k = 0; k < N; k++) begin
         cand = wrap_add(ptr, IW'(k));
         if (!any_elig && (|(elig & onehot(cand)))) begin
            winner   = cand;
            any_elig = 1'b1;
         end
      end
   end

   // Next-state, grant, timeout and mask logic
   always_comb begin
      state_nxt  = state;
      owner_nxt  = OWNER;
      ptr_nxt    = ptr;
      cnt_nxt    = '0;
      masked_nxt = MASKED & ~REQ;
      gnt_nxt    = '1;

      if (txn_start) ptr_nxt = wrap_add(OWNER, IW'(1));

      case (state)
         PARKED: begin
            owner_nxt = PARK_IDX;
            if (any_elig) state_nxt = (winner == PARK_IDX) ? GRANTED : GAP;
         end
         GRANTED: begin
            if (expire) begin
               masked_nxt = masked_nxt | onehot(OWNER);
               state_nxt  = GAP;
            end else if (idle) begin
               if (!any_elig) begin
                  state_nxt = PARKED;
                  owner_nxt = PARK_IDX;
               end else if (winner != OWNER) begin
                  state_nxt = GAP;
               end else if (inc) begin
                  cnt_nxt = cnt + CW'(1);
               end
            end else if (any_elig && (winner != OWNER)) begin
               owner_nxt = winner;
            end
         end
         default: begin
            if (any_elig) begin
               state_nxt = GRANTED;
               owner_nxt = winner;
            end else begin
               state_nxt = PARKED;
               owner_nxt = PARK_IDX;
            end
         end
      endcase

      if (state_nxt != GAP) gnt_nxt = ~onehot(owner_nxt);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= GAP;
         GNT      <= '1;
         OWNER    <= PARK_IDX;
         MASKED   <= '0;
         ptr      <= '0;
         cnt      <= '0;
         BUS_IDLE <= 1'b1;
      end else begin
         state    <= state_nxt;
         GNT      <= gnt_nxt;
         OWNER    <= owner_nxt;
         MASKED   <= masked_nxt;
         ptr      <= ptr_nxt;
         cnt      <= cnt_nxt;
         BUS_IDLE <= idle;
      end
   end
endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Bench for pci_rr_arbiter: directed scenarios plus randomized bus traffic against a rule-level model.
module tb_pci_rr_arbiter;
   localparam int N       = 4;
   localparam int PARK    = 0;
   localparam int TIMEOUT = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         frame = 1'b1;
   logic         irdy = 1'b1;
   logic [N-1:0] req = '1;
   logic [N-1:0] gnt, masked;
   logic [2:0]   owner;
   logic         bus_idle;

   always #5 clk = ~clk;

   pci_rr_arbiter #(.N(N), .PARK(PARK), .TIMEOUT(TIMEOUT)) dut (
      .CLK(clk), .RESET(reset), .FRAME(frame), .IRDY(irdy), .REQ(req),
      .GNT(gnt), .OWNER(owner), .MASKED(masked), .BUS_IDLE(bus_idle)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: holder = index whose GNT is low, -1 during a gap
   int           m_holder, m_owner, m_ptr, m_cnt;
   bit           m_parked, m_idle;
   bit [N-1:0]   m_masked;

   function automatic void model_reset();
      m_holder = -1; m_owner = PARK; m_ptr = 0; m_cnt = 0;
      m_parked = 0;  m_idle = 1;     m_masked = '0;
   endfunction

   function automatic void model_step(input bit [N-1:0] r, input bit f, input bit i);
      bit          idle_now = f && i;
      int          w = -1;
      int          nh = m_holder, nown = m_owner, nptr = m_ptr, ncnt = 0;
      bit          npark = m_parked;
      bit [N-1:0]  nmask;
      for (int k = 0; k < N; k++) begin
         int j = (m_ptr + k) % N;
         if (w < 0 && !r[j] && !m_masked[j]) w = j;
      end
      if (m_holder >= 0 && !f && m_idle) nptr = (m_owner + 1) % N;
      nmask = m_masked & ~r;
      if (m_holder < 0) begin
         if (w >= 0) begin nh = w; nown = w; npark = 0; end
         else begin nh = PARK; nown = PARK; npark = 1; end
      end else if (m_parked) begin
         if (w == PARK) npark = 0;
         else if (w >= 0) begin nh = -1; npark = 0; end
      end else begin
         if (idle_now && !r[m_owner] && m_cnt == TIMEOUT - 1) begin
            nmask[m_owner] = 1'b1;
            nh = -1;
         end else if (idle_now) begin
            if (w < 0) begin nh = PARK; nown = PARK; npark = 1; end
            else if (w != m_owner) nh = -1;
            else ncnt = m_cnt + 1;
         end else if (w >= 0 && w != m_owner) begin
            nh = w; nown = w;
         end
      end
      m_holder = nh; m_owner = nown; m_ptr = nptr; m_cnt = ncnt;
      m_parked = npark; m_masked = nmask; m_idle = idle_now;
   endfunction

   task automatic check_all();
      logic [N-1:0] eg = '1;
      if (m_holder >= 0) eg[m_holder] = 1'b0;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("masked", 32'(masked), 32'(m_masked));
      chk("bus_idle", 32'(bus_idle), 32'(m_idle));
      chk("one_gnt", 32'($countones(~gnt) <= 1), 32'd1);
   endtask

   task automatic tick(input logic [N-1:0] r, input logic f, input logic i, input logic rst);
      @(negedge clk);
      req = r; frame = f; irdy = i; reset = rst;
      @(posedge clk);
      if (rst) model_reset();
      else model_step(r, f, i);
      #1;
      check_all();
   endtask

   int nxt_owner[3] = '{2, 3, 1};

   initial begin
      int low_cnt;
      int busy_rem;
      logic [N-1:0] rq;
      model_reset();

      // reset then silence
      repeat (3) tick(4'b1111, 1'b1, 1'b1, 1'b1);
      chk("reset_gnt", 32'(gnt), 32'hF);
      tick(4'b1111, 1'b1, 1'b1, 1'b0);
      chk("park_gnt", 32'(gnt), 32'hE);
      chk("park_owner", 32'(owner), 32'd0);
      chk("park_masked", 32'(masked), 32'd0);
      chk("park_idle", 32'(bus_idle), 32'd1);

      // idle handover 0 -> 1
      tick(4'b1101, 1'b1, 1'b1, 1'b0);
      chk("handover_gap", 32'(gnt), 32'hF);
      tick(4'b1101, 1'b1, 1'b1, 1'b0);
      chk("handover_gnt", 32'(gnt), 32'hD);
      chk("handover_owner", 32'(owner), 32'd1);

      // round robin over masters 1..3, one short transaction each
      for (int s = 0; s < 3; s++) begin
         tick(4'b0001, 1'b0, 1'b0, 1'b0);
         tick(4'b0001, 1'b1, 1'b1, 1'b0);
         chk("rr_gap", 32'(gnt), 32'hF);
         tick(4'b0001, 1'b1, 1'b1, 1'b0);
         chk("rr_owner", 32'(owner), 32'(nxt_owner[s]));
      end

      // hidden arbitration during master 1's burst
      tick(4'b1101, 1'b0, 1'b0, 1'b0);
      tick(4'b1001, 1'b0, 1'b0, 1'b0);
      chk("hidden_gnt", 32'(gnt), 32'hB);
      for (int s = 0; s < 4; s++) begin
         tick(4'b1011, 1'b0, 1'b0, 1'b0);
         chk("hidden_hold", 32'(gnt), 32'hB);
      end
      tick(4'b1011, 1'b1, 1'b0, 1'b0);
      tick(4'b1011, 1'b1, 1'b1, 1'b0);
      chk("hidden_after", 32'(gnt), 32'hB);

      // reset in the middle of a burst
      tick(4'b1011, 1'b0, 1'b0, 1'b0);
      tick(4'b1011, 1'b0, 1'b0, 1'b1);
      chk("midreset_gnt", 32'(gnt), 32'hF);
      chk("midreset_owner", 32'(owner), 32'd0);
      chk("midreset_masked", 32'(masked), 32'd0);
      tick(4'b1111, 1'b1, 1'b1, 1'b0);

      // timeout of an unused grant to master 3
      tick(4'b0111, 1'b1, 1'b1, 1'b0);
      tick(4'b0111, 1'b1, 1'b1, 1'b0);
      chk("to_grant", 32'(gnt), 32'h7);
      low_cnt = 1;
      for (int s = 0; s < 40; s++) begin
         tick(4'b0111, 1'b1, 1'b1, 1'b0);
         if (gnt[3]) break;
         low_cnt++;
      end
      chk("to_len", 32'(low_cnt), 32'(TIMEOUT));
      chk("to_masked", 32'(masked), 32'h8);
      chk("to_gap", 32'(gnt), 32'hF);
      tick(4'b0111, 1'b1, 1'b1, 1'b0);
      chk("to_park", 32'(gnt), 32'hE);
      tick(4'b1111, 1'b1, 1'b1, 1'b0);
      chk("to_unmask", 32'(masked), 32'h0);

      // randomized traffic
      rq = '1;
      busy_rem = 0;
      for (int c = 0; c < 3000; c++) begin
         logic f, i, r;
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 15) == 0) rq[b] = ~rq[b];
         if (busy_rem == 0 && $urandom_range(0, 5) == 0) busy_rem = $urandom_range(2, 7);
         if (busy_rem > 0) begin
            f = (busy_rem == 1);
            i = 1'b0;
            busy_rem--;
         end else begin
            f = 1'b1;
            i = 1'b1;
         end
         r = ($urandom_range(0, 499) == 0);
         tick(rq, f, i, r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
